// File: rtl/data_mem_responder.sv
// Slow data-memory responder for the MIPS memory stage: valid/ready request in, response after
// WAIT_CYCLES wait states. Optional address checking is enabled with `define DM_ADDR_CHECK_EN.
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT             state, stateNext;
    logic [3:0]        cnt, cntNext;
    logic              accept, doAccess;
    logic [IDX_W-1:0]  idxIn, idxQ, accIdx;
    logic              errIn, errQ, accErr;
    logic              writeQ, accWrite;
    logic [31:0]       wdataQ, accWdata;
    logic [31:0]       mem [DEPTH];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign idxIn      = req_addr[IDX_W+1:2];

`ifdef DM_ADDR_CHECK_EN
    assign errIn = (req_addr[31:2] >= 30'(DEPTH)) || (req_addr[1:0] != 2'b00);
`else
    logic unusedAddr;
    assign errIn      = 1'b0;
    assign unusedAddr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
`endif

    // With zero wait states the access fires on the accept edge, straight from the live request.
    assign accIdx   = (state == IDLE) ? idxIn     : idxQ;
    assign accErr   = (state == IDLE) ? errIn     : errQ;
    assign accWrite = (state == IDLE) ? req_write : writeQ;
    assign accWdata = (state == IDLE) ? req_wdata : wdataQ;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        doAccess  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        stateNext = RESP;
                        doAccess  = 1'b1;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                cntNext = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    stateNext = RESP;
                    doAccess  = 1'b1;
                    cntNext   = 4'd0;
                end
            end
            RESP: begin
                if (resp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            idxQ       <= '0;
            errQ       <= 1'b0;
            writeQ     <= 1'b0;
            wdataQ     <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (accept) begin
                idxQ   <= idxIn;
                errQ   <= errIn;
                writeQ <= req_write;
                wdataQ <= req_wdata;
            end
            if (doAccess) begin
                resp_err   <= accErr;
                resp_rdata <= (accWrite || accErr) ? 32'd0 : mem[accIdx];
            end
        end
    end

    // NOTE: the memory array has no reset; stored words survive a reset pulse.
    always_ff @(posedge clk) begin
        if (doAccess && accWrite && !accErr) mem[accIdx] <= accWdata;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance 0 with WAIT_CYCLES=2, instance 1 with
// WAIT_CYCLES=0; a negedge monitor pops expected responses whenever a response is consumed.
module tb_data_mem_responder;
    localparam int DEPTH = 64;
`ifdef DM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } expT;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid[2], reqReady[2], reqWrite[2];
    logic        respValid[2], respReady[2], respErr[2];
    logic [31:0] reqAddr[2], reqWdata[2], respRdata[2];

    expT q0[$];
    expT q1[$];
    int  nChecks = 0;
    int  nPass   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic failNow(input string name);
        nChecks++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic int waitOf(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic compareResp(input int k, input expT e);
        check($sformatf("resp_rdata[%0d]", k), respRdata[k], e.rdata);
        check($sformatf("resp_err[%0d]", k), {31'd0, respErr[k]}, {31'd0, e.err});
    endtask

    always @(negedge clk) begin
        if (respValid[0] && respReady[0]) begin
            if (q0.size() == 0) failNow("unexpected response on inst 0");
            else compareResp(0, q0.pop_front());
        end
        if (respValid[1] && respReady[1]) begin
            if (q1.size() == 0) failNow("unexpected response on inst 1");
            else compareResp(1, q1.pop_front());
        end
    end

    // Present a request and return right after the accept edge (+1); no scoreboard entry.
    task automatic acceptOnly(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                              output bit ok);
        int n = 0;
        reqWrite[k] = w; reqAddr[k] = a; reqWdata[k] = d; reqValid[k] = 1'b1;
        while (reqReady[k] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        ok = (n < 50);
        if (!ok) failNow("req_ready wait");
        else begin @(posedge clk); #1; end
        reqValid[k] = 1'b0;
    endtask

    // Full transaction; optionally stalls resp_ready and presents a stray request meanwhile.
    task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] expD, input bit expE, input int holdLow = 0,
                         input bit stray = 1'b0);
        int  n;
        bit  ok;
        expT e;
        e.rdata = expD;
        e.err   = expE;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        acceptOnly(k, w, a, d, ok);
        if (!ok) return;
        n = 1;
        while (respValid[k] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check($sformatf("latency[%0d] addr %h", k, a), n, waitOf(k) + 1);
        if (stray) begin
            reqWrite[k] = 1'b1; reqAddr[k] = 32'h20; reqWdata[k] = 32'hBAD0BAD0; reqValid[k] = 1'b1;
        end
        for (int i = 0; i < holdLow; i++) begin
            @(posedge clk); #1;
            check("hold resp_valid", {31'd0, respValid[k]}, 32'd1);
            check("hold resp_rdata", respRdata[k], expD);
            check("hold req_ready", {31'd0, reqReady[k]}, 32'd0);
        end
        respReady[k] = 1'b1;
        @(posedge clk); #1;
        respReady[k] = 1'b0;
        reqValid[k]  = 1'b0;
        check("resp_valid after handshake", {31'd0, respValid[k]}, 32'd0);
        check("req_ready after handshake", {31'd0, reqReady[k]}, 32'd1);
    endtask

    task automatic resetState(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, " req_ready"}, {31'd0, reqReady[k]}, 32'd1);
            check({tag, " resp_valid"}, {31'd0, respValid[k]}, 32'd0);
            check({tag, " resp_rdata"}, respRdata[k], 32'd0);
            check({tag, " resp_err"}, {31'd0, respErr[k]}, 32'd0);
        end
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            reqValid[k] = 1'b0; reqWrite[k] = 1'b0; reqAddr[k] = 32'd0;
            reqWdata[k] = 32'd0; respReady[k] = 1'b0;
        end
        #1 resetState("por");
        @(posedge clk); #1 rst = 1'b0;

        // Store then load with two wait states; top word index as a boundary.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b1, 32'hFC, 32'hCAFEF00D, 32'd0, 1'b0);
        issue(0, 1'b0, 32'hFC, 32'd0, 32'hCAFEF00D, 1'b0);

        // Back-pressure: stalled response, stray store must not be taken.
        issue(0, 1'b1, 32'h20, 32'h20202020, 32'd0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 5, 1'b1);
        issue(0, 1'b0, 32'h20, 32'd0, 32'h20202020, 1'b0);

        // Zero wait states.
        issue(1, 1'b1, 32'h4, 32'h12345678, 32'd0, 1'b0);
        issue(1, 1'b0, 32'h4, 32'd0, 32'h12345678, 1'b0);

        // Asynchronous reset mid-cycle while a load response is pending.
        acceptOnly(0, 1'b0, 32'h10, 32'd0, ok);
        repeat (2) @(posedge clk);
        #1 check("pre-reset resp_rdata", respRdata[0], 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1 resetState("mid-cycle rst");
        @(posedge clk); #1 rst = 1'b0;

        // Reset in WAIT discards an uncommitted store.
        issue(0, 1'b1, 32'h8, 32'h11111111, 32'd0, 1'b0);
        acceptOnly(0, 1'b1, 32'h8, 32'hAAAA0000, ok);
        #2 rst = 1'b1;
        #1 check("rst in WAIT req_ready", {31'd0, reqReady[0]}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        issue(0, 1'b0, 32'h8, 32'd0, 32'h11111111, 1'b0);

        // Out-of-range address: error with the check, wrap without it.
        issue(0, 1'b1, 32'h0, 32'h0C0C0C0C, 32'd0, 1'b0);
        issue(0, 1'b1, 32'h100, 32'h55, 32'd0, CHK);
        issue(0, 1'b0, 32'h0, 32'd0, CHK ? 32'h0C0C0C0C : 32'h55, 1'b0);
        issue(0, 1'b0, 32'h1000, 32'd0, CHK ? 32'd0 : 32'h55, CHK);
        if (CHK) issue(0, 1'b0, 32'h6, 32'd0, 32'd0, 1'b1);

        repeat (2) @(posedge clk);
        check("scoreboard 0 drained", q0.size(), 32'd0);
        check("scoreboard 1 drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
